// File: rtl/pixel_ingress_if.sv
`default_nettype none
// ============================================================================
// Module : pixel_ingress_if
// Brief  : Raw-pixel input stream and core-facing output bundle for pixel_ingress.
// Rev    : 1.0  initial release
// ============================================================================
interface pixel_ingress_if #(
   parameter int PIXEL_WIDTH = 8,
   parameter int DATA_WIDTH  = 24,
   parameter int FIFO_DEPTH  = 16
);
   logic                        s_valid;
   logic                        s_ready;
   logic [PIXEL_WIDTH-1:0]      s_data;
   logic                        s_last;
   logic                        o_valid;
   logic [DATA_WIDTH-1:0]       pixel;
   logic                        o_last;
   logic                        frame_done;
   logic                        frame_err;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, o_valid, pixel, o_last, frame_done, frame_err, fifo_level
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, o_valid, pixel, o_last, frame_done, frame_err, fifo_level
   );
endinterface
`default_nettype wire

// File: rtl/pixel_ingress.sv
`default_nettype none
// ============================================================================
// Module : pixel_ingress
// Brief  : FIFO-buffered pixel feeder: 8-bit to fixed-point, frame counting,
//          fixed inter-frame gap. PIXEL_INGRESS_LAST_CHECK_EN enables s_last checking.
// Rev    : 1.0  initial release
// ============================================================================
module pixel_ingress #(
   parameter int DATA_WIDTH   = 24,
   parameter int PIXEL_WIDTH  = 8,
   parameter int FRAC_BITS    = 16,
   parameter int IMAGE_PIXELS = 784,
   parameter int FIFO_DEPTH   = 16,
   parameter int GAP_CYCLES   = 512
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   pixel_ingress_if.slave bus
);
   localparam int c_aw      = $clog2(FIFO_DEPTH);
   localparam int c_lw      = c_aw + 1;
   localparam int c_cw      = (IMAGE_PIXELS > 1) ? $clog2(IMAGE_PIXELS) : 1;
   localparam int c_gw      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int c_shift   = FRAC_BITS - PIXEL_WIDTH;
   localparam bit c_has_gap = (GAP_CYCLES > 0);
`ifdef PIXEL_INGRESS_LAST_CHECK_EN
   localparam int c_fw      = PIXEL_WIDTH + 1;
`else
   localparam int c_fw      = PIXEL_WIDTH;
`endif
   localparam logic [c_lw-1:0] c_depth    = c_lw'(FIFO_DEPTH);
   localparam logic [c_cw-1:0] c_last_idx = c_cw'(IMAGE_PIXELS - 1);
   localparam logic [c_gw-1:0] c_gap_last = c_gw'(c_has_gap ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [c_fw-1:0]         r_mem [FIFO_DEPTH];
   logic [c_aw-1:0]         r_wr_ptr;
   logic [c_aw-1:0]         r_rd_ptr;
   logic [c_lw-1:0]         r_level;
   logic [c_lw-1:0]         w_level_nxt;
   logic                    r_ready;
   logic [c_cw-1:0]         r_pix_cnt;
   logic [c_gw-1:0]         r_gap_cnt;
   logic                    r_valid;
   logic [DATA_WIDTH-1:0]   r_pixel;
   logic                    r_last;
   logic                    r_done;
   logic                    r_err;

   logic                    w_push;
   logic                    w_pop;
   logic [c_fw-1:0]         w_wr_word;
   logic [c_fw-1:0]         w_rd_word;
   logic [PIXEL_WIDTH-1:0]  w_rd_data;
   logic                    w_rd_last;
   logic                    w_cnt_last;
   logic                    w_beat_last;
   logic                    w_err;
   logic [DATA_WIDTH-1:0]   w_conv;

   assign w_push    = bus.s_valid && r_ready;
   assign w_pop     = (r_state != S_GAP) && (r_level != '0);
   assign w_rd_word = r_mem[r_rd_ptr];
   assign w_rd_data = w_rd_word[PIXEL_WIDTH-1:0];

`ifdef PIXEL_INGRESS_LAST_CHECK_EN
   assign w_wr_word = {bus.s_last, bus.s_data};
   assign w_rd_last = w_rd_word[PIXEL_WIDTH];
   assign w_err     = w_rd_last ^ w_cnt_last;
`else
   logic w_unused;
   assign w_wr_word = bus.s_data;
   assign w_rd_last = 1'b0;
   assign w_err     = 1'b0;
   assign w_unused  = bus.s_last;
`endif

   // A tagged last beat closes the frame early so pix_cnt resyncs to 0.
   assign w_cnt_last  = (r_pix_cnt == c_last_idx);
   assign w_beat_last = w_cnt_last | w_rd_last;
   assign w_conv      = DATA_WIDTH'(w_rd_data) << c_shift;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + c_lw'(1);
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - c_lw'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_STREAM: begin
            if (w_pop) begin
               if (!w_beat_last)   w_state_nxt = S_STREAM;
               else if (c_has_gap) w_state_nxt = S_GAP;
               else                w_state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == c_gap_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_wr_word;
   end

   // s_ready is registered from the next level, so a full FIFO never bypasses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_ready   <= 1'b0;
         r_pix_cnt <= '0;
         r_gap_cnt <= '0;
         r_valid   <= 1'b0;
         r_pixel   <= '0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_level   <= w_level_nxt;
         r_ready   <= (w_level_nxt < c_depth);
         if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + c_aw'(1);
            r_pix_cnt <= w_beat_last ? '0 : r_pix_cnt + c_cw'(1);
         end
         r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + c_gw'(1) : '0;
         r_valid   <= w_pop;
         r_pixel   <= w_pop ? w_conv : '0;
         r_last    <= w_pop && w_beat_last;
         r_done    <= r_last;
         r_err     <= r_err | (w_pop & w_err);
      end
   end

   assign bus.s_ready    = r_ready;
   assign bus.o_valid    = r_valid;
   assign bus.pixel      = r_pixel;
   assign bus.o_last     = r_last;
   assign bus.frame_done = r_done;
   assign bus.frame_err  = r_err;
   assign bus.fifo_level = r_level;
endmodule
`default_nettype wire

// File: tb/tb_pixel_ingress.sv
`default_nettype none
// ============================================================================
// Module : tb_pixel_ingress
// Brief  : Directed self-checking bench for pixel_ingress with a scoreboard model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pixel_ingress;
   localparam int IMG = 784;
   localparam int GAP = 512;

   logic clk;
   logic rst_n;

   pixel_ingress_if #(.PIXEL_WIDTH(8), .DATA_WIDTH(24), .FIFO_DEPTH(16)) bus ();

   pixel_ingress #(
      .DATA_WIDTH(24), .PIXEL_WIDTH(8), .FRAC_BITS(16),
      .IMAGE_PIXELS(IMG), .FIFO_DEPTH(16), .GAP_CYCLES(GAP)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] q[$];
   int         mcnt    = 0;
   bit         prev_last = 0;
   bit         err_m   = 0;
   bit         gap_arm = 0;
   int         zeros   = 0;
   int         zb;
   int         lpos;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] conv(input logic [7:0] b);
      return {8'h00, b, 8'h00};
   endfunction

   task automatic cycle();
      logic [8:0] e;
      bit         exp_last;
      @(posedge clk);
      #1;
      chk("frame_done", bus.frame_done, prev_last);
      prev_last = 0;
      if (bus.o_valid === 1'b1) begin
         if (gap_arm) begin
            chk("gap_len", zeros, GAP);
            gap_arm = 0;
         end
         zeros = 0;
         if (q.size() == 0) begin
            chk("sb_underrun", bus.o_valid, 0);
         end else begin
            e = q.pop_front();
            exp_last = (mcnt == IMG - 1);
`ifdef PIXEL_INGRESS_LAST_CHECK_EN
            if (e[8] != exp_last) err_m = 1;
            exp_last = exp_last | e[8];
`endif
            chk("pixel", bus.pixel, conv(e[7:0]));
            chk("o_last", bus.o_last, exp_last);
            mcnt = exp_last ? 0 : mcnt + 1;
            prev_last = exp_last;
         end
      end else begin
         zeros++;
         chk("o_last_idle", bus.o_last, 0);
      end
      chk("frame_err", bus.frame_err, err_m);
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      q.push_back({l, d});
      cycle();
   endtask

   task automatic idle();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      cycle();
   endtask

   task automatic wait_beat(input string tag);
      for (int i = 0; i < 600 && bus.o_valid !== 1'b1; i++) idle();
      chk(tag, bus.o_valid, 1);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
`ifdef PIXEL_INGRESS_LAST_CHECK_EN
      lpos = -1;
`else
      lpos = 100;
`endif

      // Reset state and release
      #2;
      chk("rst_outs", {bus.s_ready, bus.o_valid, bus.o_last, bus.frame_done,
                       bus.frame_err, bus.fifo_level, bus.pixel}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rdy_pre", bus.s_ready, 0);
      idle();
      chk("rdy_post", bus.s_ready, 1);
      for (int i = 0; i < 20; i++) begin
         idle();
         chk("idle_outs", {bus.o_valid, bus.o_last, bus.frame_done, bus.frame_err,
                           bus.fifo_level, bus.pixel}, 0);
         chk("idle_rdy", bus.s_ready, 1);
      end

      // Conversion and one-cycle latency
      push(8'h00, 1'b0);
      chk("lat_k", bus.o_valid, 0);
      push(8'h80, 1'b0);
      chk("lat_v0", bus.o_valid, 1);
      chk("lat_p0", bus.pixel, 24'h000000);
      push(8'hFF, 1'b0);
      chk("lat_p1", bus.pixel, 24'h008000);
      chk("lat_lvl", bus.fifo_level, 1);
      idle();
      chk("lat_p2", bus.pixel, 24'h00FF00);
      chk("lat_v2", bus.o_valid, 1);
      idle();
      chk("lat_end", bus.o_valid, 0);

      // Complete frame 1 (3 beats already out), then fill FIFO in the gap
      for (int i = 0; i < IMG - 3; i++) push(8'(i * 37 + 11), 1'b0);
      idle();
      chk("t4_last", bus.o_last, 1);
      gap_arm = 1;
      idle();
      chk("t4_done", bus.frame_done, 1);
      chk("t4_gap0", bus.o_valid, 0);
      for (int i = 0; i < 16; i++) begin
         push(8'(200 + i), 1'b0);
         if (i == 14) begin
            chk("t3_rdy15", bus.s_ready, 1);
            chk("t3_lvl15", bus.fifo_level, 15);
         end
      end
      chk("t3_rdy16", bus.s_ready, 0);
      chk("t3_lvl16", bus.fifo_level, 16);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hEE;
      cycle();
      chk("t3_17th", bus.fifo_level, 16);
      bus.s_valid = 1'b0;
      wait_beat("t4_gap_end");

      // Frame 2 back-to-back: 1 + 768 + 15 beats
      zb = 0;
      for (int i = 0; i < 768; i++) begin
         push(8'(i * 5 + 1), 1'b0);
         if (bus.o_valid !== 1'b1) zb++;
      end
      for (int i = 0; i < 15; i++) begin
         idle();
         if (bus.o_valid !== 1'b1) zb++;
      end
      chk("t4_b2b", zb, 0);
      chk("t4_last2", bus.o_last, 1);
      gap_arm = 1;
      idle();
      chk("t4_done2", bus.frame_done, 1);

      // Reset at beat 300 with 10 bytes buffered
      for (int i = 0; i < 11; i++) push(8'(i * 3 + 90), 1'b0);
      wait_beat("t5_gap_end");
      for (int i = 0; i < 400 && mcnt != 300; i++) push(8'(i ^ 8'h5C), 1'b0);
      chk("t5_beat300", mcnt, 300);
      chk("t5_lvl", bus.fifo_level, 10);
      bus.s_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_outs", {bus.s_ready, bus.o_valid, bus.o_last, bus.frame_done,
                          bus.frame_err, bus.fifo_level, bus.pixel}, 0);
      q.delete();
      mcnt = 0; prev_last = 0; err_m = 0; zeros = 0; gap_arm = 0;
      repeat (3) idle();
      rst_n = 1'b1;
      idle();
      chk("t5_rdy", bus.s_ready, 1);
      for (int i = 0; i < IMG; i++) push(8'(i * 11 + 7), 1'(i == lpos));
      idle();
      chk("t5_last", bus.o_last, 1);
      chk("t5_noerr", bus.frame_err, 0);

`ifdef PIXEL_INGRESS_LAST_CHECK_EN
      // Early s_last flags error, closes frame, and gap follows
      for (int i = 0; i < 520; i++) idle();
      chk("t6_err0", bus.frame_err, 0);
      for (int i = 0; i < 500; i++) push(8'(i), 1'(i == 499));
      idle();
      chk("t6_last", bus.o_last, 1);
      chk("t6_err", bus.frame_err, 1);
      gap_arm = 1;
      idle();
      chk("t6_done", bus.frame_done, 1);
      push(8'h5A, 1'b0);
      wait_beat("t6_gap_end");
      for (int i = 0; i < IMG - 2; i++) push(8'(i + 3), 1'b0);
      push(8'hA5, 1'b1);
      idle();
      chk("t6_last2", bus.o_last, 1);
      chk("t6_sticky", bus.frame_err, 1);
`endif

      repeat (3) idle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
